// File: rtl/calc_pkg.sv
// Shared encodings for the UART calculator execution stage.
package calc_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam logic [3:0] DT_SIGNED   = 4'h1;
  localparam logic [3:0] DT_UNSIGNED = 4'h2;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge, so done rises DW cycles after start.
module calc_divider #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] quot_q, rem_q, dvsr_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [DW-1:0] src_quot, src_rem, src_dvsr;
  logic [DW:0]   shifted;
  logic          fits;
  logic [DW-1:0] rem_next, quot_next;

  always_comb begin
    src_quot  = start ? dividend : quot_q;
    src_rem   = start ? '0 : rem_q;
    src_dvsr  = start ? divisor : dvsr_q;
    shifted   = {src_rem, src_quot[DW-1]};
    fits      = shifted >= {1'b0, src_dvsr};
    rem_next  = fits ? DW'(shifted - {1'b0, src_dvsr}) : shifted[DW-1:0];
    quot_next = {src_quot[DW-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      quot_q <= quot_next;
      rem_q  <= rem_next;
      dvsr_q <= divisor;
      cnt_q  <= CW'(1);
      run_q  <= 1'b1;
      done   <= 1'b0;
    end else if (run_q) begin
      quot_q <= quot_next;
      rem_q  <= rem_next;
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == CW'(DW - 1)) begin
        run_q <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_alu.sv
// Calculator execution stage: add/sub/mul/div, signed or unsigned, multi-cycle.
// Define CALC_FAST_MUL_EN for a single-cycle combinational multiplier.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ITER = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      dtype,
  input  logic [4:0]      operator,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  input  logic            parser_done,
  output logic            busy,
  output logic [2*DW-1:0] result,
  output logic [DW-1:0]   remainder,
  output logic            err,
  output logic            result_valid
);

  localparam int CW = $clog2(ITER);
  localparam int RW = 2 * DW;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [4:0]    op_q;
  logic          sgn_mode_q, neg_a_q, neg_b_q, bad_q, div0_q;
  logic [DW-1:0] a_q, b_q, mag_a_q, mag_b_q;

  logic          accept, in_signed, in_bad, in_neg_a, in_neg_b, div_start;
  logic [DW-1:0] in_mag_a, in_mag_b;
  logic          div_done;
  logic [DW-1:0] div_quot, div_rem;
  logic          exec_last;
  logic [RW-1:0] mul_mag, md_mag, md_signed, ext_a, ext_b, addsub;
  logic [DW-1:0] rem_signed;

  always_comb begin
    accept    = (state_q == ST_IDLE) && parser_done;
    in_signed = (dtype == DT_SIGNED);
    in_bad    = !((dtype == DT_SIGNED) || (dtype == DT_UNSIGNED)) ||
                !((operator == OP_ADD) || (operator == OP_SUB) ||
                  (operator == OP_MUL) || (operator == OP_DIV));
    in_neg_a  = in_signed && src1[DW-1];
    in_neg_b  = in_signed && src2[DW-1];
    in_mag_a  = in_neg_a ? DW'(-src1) : src1;
    in_mag_b  = in_neg_b ? DW'(-src2) : src2;
    div_start = accept && !in_bad && (operator == OP_DIV) && (src2 != '0);
  end

  calc_divider #(.DW(DW)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (in_mag_a),
    .divisor   (in_mag_b),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

`ifdef CALC_FAST_MUL_EN
  always_comb mul_mag = RW'(mag_a_q) * RW'(mag_b_q);
`else
  logic [RW-1:0] acc_q;
  logic [RW-1:0] mul_term;

  // Shift-add: bit cnt of the multiplier selects multiplicand<<cnt.
  always_comb begin
    mul_term = RW'(mag_a_q) << cnt_q;
    mul_mag  = mag_b_q[cnt_q] ? (acc_q + mul_term) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst || accept) acc_q <= '0;
    else if (state_q == ST_EXEC) acc_q <= mul_mag;
  end
`endif

  always_comb begin
    exec_last = 1'b1;
    if (!bad_q && (op_q == OP_DIV) && !div0_q) exec_last = div_done;
`ifndef CALC_FAST_MUL_EN
    else if (!bad_q && (op_q == OP_MUL)) exec_last = (cnt_q == CW'(ITER - 1));
`endif
  end

  always_comb begin
    md_mag     = (op_q == OP_DIV) ? RW'(div_quot) : mul_mag;
    md_signed  = (neg_a_q ^ neg_b_q) ? RW'(-md_mag) : md_mag;
    ext_a      = sgn_mode_q ? {{DW{a_q[DW-1]}}, a_q} : RW'(a_q);
    ext_b      = sgn_mode_q ? {{DW{b_q[DW-1]}}, b_q} : RW'(b_q);
    addsub     = (op_q == OP_ADD) ? (ext_a + ext_b) : (ext_a - ext_b);
    rem_signed = neg_a_q ? DW'(-div_rem) : div_rem;
  end

  always_comb begin
    state_d      = state_q;
    busy         = (state_q != ST_IDLE);
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (parser_done) state_d = ST_EXEC;
      ST_EXEC: if (exec_last) state_d = ST_DONE;
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= '0;
      sgn_mode_q <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      bad_q      <= 1'b0;
      div0_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      result     <= '0;
      remainder  <= '0;
      err        <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      op_q       <= operator;
      sgn_mode_q <= in_signed;
      neg_a_q    <= in_neg_a;
      neg_b_q    <= in_neg_b;
      bad_q      <= in_bad;
      div0_q     <= !in_bad && (operator == OP_DIV) && (src2 == '0);
      a_q        <= src1;
      b_q        <= src2;
      mag_a_q    <= in_mag_a;
      mag_b_q    <= in_mag_b;
      err        <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      cnt_q <= cnt_q + 1'b1;
      if (exec_last) begin
        if (bad_q) begin
          err       <= 1'b1;
          result    <= '0;
          remainder <= '0;
        end else if (div0_q) begin
          err       <= 1'b1;
          result    <= DIV0_RESULT;
          remainder <= a_q;
        end else if (op_q == OP_DIV) begin
          result    <= md_signed;
          remainder <= rem_signed;
        end else if (op_q == OP_MUL) begin
          result    <= md_signed;
          remainder <= '0;
        end else begin
          result    <= addsub;
          remainder <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_alu.sv
// Directed vector bench for calc_alu plus busy-ignore, reset-abort and DONE-overlap sequences.
module tb_calc_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1, src2;
  logic        parser_done;
  logic        busy, err, result_valid;
  logic [31:0] result;
  logic [15:0] remainder;

  int total = 0;
  int bad   = 0;

`ifdef CALC_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 17;
`endif

  typedef struct {
    logic [3:0]  dt;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [15:0] rem;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  calc_alu dut (
    .clk          (clk),
    .rst          (rst),
    .dtype        (dtype),
    .operator     (operator),
    .src1         (src1),
    .src2         (src2),
    .parser_done  (parser_done),
    .busy         (busy),
    .result       (result),
    .remainder    (remainder),
    .err          (err),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] dt, logic [4:0] op, logic [15:0] a, logic [15:0] b,
                              logic [31:0] res, logic [15:0] rem, logic er, int lat);
    vec_t v;
    v.dt = dt; v.op = op; v.a = a; v.b = b;
    v.res = res; v.rem = rem; v.er = er; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] dt, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b);
    @(negedge clk);
    dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    launch(v.dt, v.op, v.a, v.b);
    chk($sformatf("v%0d busy_c1", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d err_clear_c1", idx), 32'(err), 32'd0);
    cyc = 1;
    while (!result_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d remainder", idx), 32'(remainder), 32'(v.rem));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.er));
    @(posedge clk); #1;
    chk($sformatf("v%0d valid_drop", idx), 32'(result_valid), 32'd0);
    chk($sformatf("v%0d result_hold", idx), result, v.res);
  endtask

  initial begin
    int pulses;
    vecs[0]  = mk(4'h2, 5'h01, 16'h1234, 16'h0FFF, 32'h0000_2233, 16'h0000, 1'b0, 2);
    vecs[1]  = mk(4'h2, 5'h02, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 16'h0000, 1'b0, 2);
    vecs[2]  = mk(4'h1, 5'h01, 16'hFFFF, 16'h0001, 32'h0000_0000, 16'h0000, 1'b0, 2);
    vecs[3]  = mk(4'h1, 5'h03, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 16'h0000, 1'b0, MUL_LAT);
    vecs[4]  = mk(4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16'h0000, 1'b0, MUL_LAT);
    vecs[5]  = mk(4'h2, 5'h04, 16'd100,  16'd7,    32'd14,         16'd2,    1'b0, 17);
    vecs[6]  = mk(4'h1, 5'h04, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 16'hFFFF, 1'b0, 17);
    vecs[7]  = mk(4'h1, 5'h04, 16'h8000, 16'hFFFF, 32'h0000_8000, 16'h0000, 1'b0, 17);
    vecs[8]  = mk(4'h2, 5'h04, 16'h00AB, 16'h0000, 32'hFFFF_FFFF, 16'h00AB, 1'b1, 2);
    vecs[9]  = mk(4'h2, 5'h07, 16'h0011, 16'h0022, 32'h0000_0000, 16'h0000, 1'b1, 2);
    vecs[10] = mk(4'h3, 5'h01, 16'h0011, 16'h0022, 32'h0000_0000, 16'h0000, 1'b1, 2);
    vecs[11] = mk(4'h1, 5'h02, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 16'h0000, 1'b0, 2);
    vecs[12] = mk(4'h2, 5'h01, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 16'h0000, 1'b0, 2);
    vecs[13] = mk(4'h1, 5'h03, 16'h7FFF, 16'h8000, 32'hC000_8000, 16'h0000, 1'b0, MUL_LAT);
    vecs[14] = mk(4'h1, 5'h04, 16'h0007, 16'hFFFE, 32'hFFFF_FFFD, 16'h0001, 1'b0, 17);
    vecs[15] = mk(4'h2, 5'h04, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 16'h0000, 1'b0, 17);
    vecs[16] = mk(4'h2, 5'h04, 16'h0005, 16'h0007, 32'h0000_0000, 16'h0005, 1'b0, 17);

    rst = 1'b1; parser_done = 1'b0; dtype = '0; operator = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // parser_done during a running divide must be dropped
    launch(4'h2, 5'h04, 16'd100, 16'd7);
    pulses = 0;
    for (int c = 1; c < 40; c++) begin
      if (c == 5) begin
        dtype = 4'h2; operator = 5'h01; src1 = 16'd1; src2 = 16'd1; parser_done = 1'b1;
      end else begin
        parser_done = 1'b0;
      end
      if (result_valid) begin
        pulses++;
        chk("busy_ignore result", result, 32'd14);
        chk("busy_ignore latency", 32'(c), 32'd17);
      end
      @(posedge clk); #1;
    end
    parser_done = 1'b0;
    chk("busy_ignore pulses", 32'(pulses), 32'd1);

    // parser_done coincident with DONE is ignored
    launch(4'h2, 5'h01, 16'd1, 16'd2);
    @(posedge clk); #1;
    chk("done_overlap valid", 32'(result_valid), 32'd1);
    dtype = 4'h2; operator = 5'h01; src1 = 16'd5; src2 = 16'd5; parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    chk("done_overlap idle", 32'(busy), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    chk("done_overlap pulses", 32'(pulses), 32'd0);
    chk("done_overlap result", result, 32'd3);

    // reset during EXEC aborts without a result
    launch(4'h2, 5'h04, 16'd100, 16'd7);
    pulses = 0;
    for (int c = 1; c < 8; c++) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort err", 32'(err), 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("abort pulses", 32'(pulses), 32'd0);
    run_vec(vecs[5], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
